// File: rtl/one_location_serializer_pkg.sv
// Shared constants and FSM state type for the one-location serializer.
// N/LOC_W/PC_W describe the fixed 8-bit byte design point.
package one_loc_pkg;

    localparam int N      = 8;
    localparam int LOC_W  = 3;
    localparam int PC_W   = 4;
    localparam int MAX_PC = 8;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

endpackage

// File: rtl/one_location_serializer_if.sv
// Bundle-in / location-stream-out signal group for the one-location serializer.
// The master side is the upstream producer plus downstream consumer; slave is the serializer.
interface one_location_serializer_if;
    import one_loc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [PC_W-1:0]  PC;
    logic [LOC_W-1:0] L0;
    logic [LOC_W-1:0] L1;
    logic [LOC_W-1:0] L2;
    logic [LOC_W-1:0] L3;
    logic [LOC_W-1:0] L4;
    logic [LOC_W-1:0] L5;
    logic [LOC_W-1:0] L6;
    logic [LOC_W-1:0] L7;

    logic             loc_valid;
    logic             loc_ready;
    logic [LOC_W-1:0] loc;
    logic [LOC_W-1:0] loc_idx;
    logic             loc_last;
    logic             done;
    logic             pc_err;

    modport master (
        output in_valid, PC, L0, L1, L2, L3, L4, L5, L6, L7, loc_ready,
        input  in_ready, loc_valid, loc, loc_idx, loc_last, done, pc_err
    );

    modport slave (
        input  in_valid, PC, L0, L1, L2, L3, L4, L5, L6, L7, loc_ready,
        output in_ready, loc_valid, loc, loc_idx, loc_last, done, pc_err
    );

endinterface

// File: rtl/one_location_serializer.sv
// Serializes a byte's ordered 1-locations into one beat per cycle with last/done marking.
// Define ONE_LOC_BACK_TO_BACK_EN to accept the next bundle on the final beat (no IDLE bubble).
module one_location_serializer
    import one_loc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    one_location_serializer_if.slave  bus
);

    state_t           state_q, state_d;
    logic [LOC_W-1:0] held_q [N];
    logic [LOC_W-1:0] held_d [N];
    logic [PC_W-1:0]  cnt_q, cnt_d;
    logic [LOC_W-1:0] idx_q, idx_d;
    logic             loc_valid_q, loc_valid_d;
    logic [LOC_W-1:0] loc_q, loc_d;
    logic             loc_last_q, loc_last_d;
    logic             done_q, done_d;
    logic             pc_err_q, pc_err_d;

    logic             in_ready;
    logic             accept;
    logic             beat;
    logic             pc_over;
    logic [PC_W-1:0]  pc_clamped;
    logic [LOC_W-1:0] idx_nxt;
    logic [LOC_W-1:0] l_in [N];

`ifdef ONE_LOC_BACK_TO_BACK_EN
    assign in_ready = (state_q == IDLE) | (loc_valid_q & bus.loc_ready & loc_last_q);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept     = bus.in_valid & in_ready;
    assign beat       = loc_valid_q & bus.loc_ready;
    assign pc_over    = bus.PC > PC_W'(MAX_PC);
    assign pc_clamped = pc_over ? PC_W'(MAX_PC) : bus.PC;
    assign idx_nxt    = idx_q + LOC_W'(1);

    always_comb begin
        l_in[0] = bus.L0;
        l_in[1] = bus.L1;
        l_in[2] = bus.L2;
        l_in[3] = bus.L3;
        l_in[4] = bus.L4;
        l_in[5] = bus.L5;
        l_in[6] = bus.L6;
        l_in[7] = bus.L7;
    end

    // A new bundle is applied after beat retirement so that, in back-to-back
    // mode, the load of the next byte overrides the return to IDLE.
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        loc_valid_d = loc_valid_q;
        loc_d       = loc_q;
        loc_last_d  = loc_last_q;
        done_d      = 1'b0;
        pc_err_d    = pc_err_q;

        if (beat) begin
            if (loc_last_q) begin
                state_d     = IDLE;
                loc_valid_d = 1'b0;
                loc_last_d  = 1'b0;
                done_d      = 1'b1;
            end else begin
                idx_d      = idx_nxt;
                loc_d      = held_q[idx_nxt];
                loc_last_d = ({1'b0, idx_nxt} == (cnt_q - PC_W'(1)));
            end
        end

        if (accept) begin
            held_d   = l_in;
            cnt_d    = pc_clamped;
            pc_err_d = pc_err_q | pc_over;
            if (pc_clamped == '0) begin
                state_d     = IDLE;
                loc_valid_d = 1'b0;
                loc_last_d  = 1'b0;
                done_d      = 1'b1;
            end else begin
                state_d     = EMIT;
                idx_d       = '0;
                loc_valid_d = 1'b1;
                loc_d       = l_in[0];
                loc_last_d  = (pc_clamped == PC_W'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            held_q      <= '{default: '0};
            cnt_q       <= '0;
            idx_q       <= '0;
            loc_valid_q <= 1'b0;
            loc_q       <= '0;
            loc_last_q  <= 1'b0;
            done_q      <= 1'b0;
            pc_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            loc_valid_q <= loc_valid_d;
            loc_q       <= loc_d;
            loc_last_q  <= loc_last_d;
            done_q      <= done_d;
            pc_err_q    <= pc_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.loc_valid = loc_valid_q;
    assign bus.loc       = loc_q;
    assign bus.loc_idx   = idx_q;
    assign bus.loc_last  = loc_last_q;
    assign bus.done      = done_q;
    assign bus.pc_err    = pc_err_q;

endmodule

// File: tb/tb_one_location_serializer.sv
// Directed bench for one_location_serializer: expected beats are queued when a bundle
// is driven and popped by a negedge monitor as the DUT emits them.
module tb_one_location_serializer;
    import one_loc_pkg::*;

    typedef struct packed {
        logic [2:0] loc;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    one_location_serializer_if bus ();

    one_location_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t      sb [$];
    int         beat_cycs [$];
    int         done_cycs [$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         hs_cyc;
    int         h1;
    int         d0;
    logic       timed_out;
    beat_t      e;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_loc;
    logic [2:0] prev_idx;
    logic       prev_last;

    localparam logic [23:0] LOCS_D3  = {3'd0, 3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd0};
    localparam logic [23:0] LOCS_ALL = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

`ifdef ONE_LOC_BACK_TO_BACK_EN
    localparam int BYTE_GAP = 1;
`else
    localparam int BYTE_GAP = 2;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Monitor: scoreboard pop on every accepted beat, stability check on stalled beats.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", bus.loc_valid, 1);
                checkOutput("stall_loc", bus.loc, prev_loc);
                checkOutput("stall_idx", bus.loc_idx, prev_idx);
                checkOutput("stall_last", bus.loc_last, prev_last);
            end
            if (bus.loc_valid && bus.loc_ready) begin
                beat_cycs.push_back(cyc);
                checkOutput("beat_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("beat_loc", bus.loc, e.loc);
                    checkOutput("beat_idx", bus.loc_idx, e.idx);
                    checkOutput("beat_last", bus.loc_last, e.last);
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cycs.push_back(cyc);
            end
            prev_stall = bus.loc_valid && !bus.loc_ready;
            prev_loc   = bus.loc;
            prev_idx   = bus.loc_idx;
            prev_last  = bus.loc_last;
        end
    end

    task automatic applyStimulus(input int pc, input logic [23:0] locs);
        int k;
        k = (pc > MAX_PC) ? MAX_PC : pc;
        for (int i = 0; i < k; i++)
            sb.push_back('{loc: locs[3*i +: 3], idx: 3'(i), last: (i == k - 1)});
        bus.in_valid = 1'b1;
        bus.PC = 4'(pc);
        bus.L0 = locs[2:0];
        bus.L1 = locs[5:3];
        bus.L2 = locs[8:6];
        bus.L3 = locs[11:9];
        bus.L4 = locs[14:12];
        bus.L5 = locs[17:15];
        bus.L6 = locs[20:18];
        bus.L7 = locs[23:21];
        timed_out = 1'b0;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (n >= 50) begin
                timed_out = 1'b1;
                break;
            end
        end
        checkOutput("accept_timeout", timed_out, 0);
        hs_cyc = cyc + 1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        timed_out = 1'b0;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
            if (n >= 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        checkOutput(tag, timed_out, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
        checkOutput({tag, "_loc_valid"}, bus.loc_valid, 0);
        checkOutput({tag, "_loc"}, bus.loc, 0);
        checkOutput({tag, "_loc_idx"}, bus.loc_idx, 0);
        checkOutput({tag, "_loc_last"}, bus.loc_last, 0);
        checkOutput({tag, "_done"}, bus.done, 0);
        checkOutput({tag, "_pc_err"}, bus.pc_err, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: observed hang expected finish");
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
        int pat [11] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.loc_ready = 1'b1;
        bus.PC = '0;
        {bus.L0, bus.L1, bus.L2, bus.L3, bus.L4, bus.L5, bus.L6, bus.L7} = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;

        $display("[TB] byte 0xD3 with loc_ready high");
        beat_cycs.delete();
        done_cycs.delete();
        applyStimulus(5, LOCS_D3);
        waitDrain("d3_drain");
        checkOutput("d3_beats", beat_cycs.size(), 5);
        checkOutput("d3_first_latency", beat_cycs[0], hs_cyc);
        checkOutput("d3_last_cycle", beat_cycs[4], hs_cyc + 4);
        checkOutput("d3_done_count", done_cycs.size(), 1);
        checkOutput("d3_done_cycle", done_cycs[0], hs_cyc + 5);

        $display("[TB] byte 0xD3 with stalls on 2nd and 4th beats");
        beat_cycs.delete();
        done_cycs.delete();
        applyStimulus(5, LOCS_D3);
        for (int i = 0; i < 11; i++) begin
            bus.loc_ready = (pat[i] != 0);
            @(posedge clk);
            #1;
        end
        bus.loc_ready = 1'b1;
        waitDrain("stall_drain");
        checkOutput("stall_beats", beat_cycs.size(), 5);
        checkOutput("stall_last_cycle", beat_cycs[4], hs_cyc + 10);
        checkOutput("stall_done_count", done_cycs.size(), 1);

        $display("[TB] PC=0 bundle");
        done_cycs.delete();
        beat_cycs.delete();
        applyStimulus(0, LOCS_D3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("pc0_in_ready", bus.in_ready, 1);
            checkOutput("pc0_loc_valid", bus.loc_valid, 0);
        end
        waitDrain("pc0_drain");
        checkOutput("pc0_beats", beat_cycs.size(), 0);
        checkOutput("pc0_done_count", done_cycs.size(), 1);
        checkOutput("pc0_done_cycle", done_cycs[0], hs_cyc);

        $display("[TB] PC=8 then PC=1 back to back");
        done_cycs.delete();
        beat_cycs.delete();
        applyStimulus(8, LOCS_ALL);
        h1 = hs_cyc;
        applyStimulus(1, {21'd0, 3'd3});
        waitDrain("b2b_drain");
        checkOutput("b2b_beats", beat_cycs.size(), 9);
        checkOutput("b2b_last_of_first", beat_cycs[7], h1 + 7);
        checkOutput("b2b_gap", beat_cycs[8] - beat_cycs[7], BYTE_GAP);
        checkOutput("b2b_done_count", done_cycs.size(), 2);
        checkOutput("b2b_second_done", done_cycs[1], h1 + 8 + BYTE_GAP);

        $display("[TB] reset during EMIT at idx 2");
        d0 = done_cnt;
        applyStimulus(5, LOCS_D3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("midrst");
        checkOutput("midrst_no_done", done_cnt - d0, 0);
        @(posedge clk);
        #1;
        beat_cycs.delete();
        applyStimulus(2, {18'd0, 3'd5, 3'd2});
        waitDrain("midrst_drain");
        checkOutput("midrst_next_beats", beat_cycs.size(), 2);

        $display("[TB] PC=12 clamps and sets pc_err");
        beat_cycs.delete();
        applyStimulus(12, LOCS_ALL);
        waitDrain("pc12_drain");
        checkOutput("pc12_beats", beat_cycs.size(), 8);
        checkOutput("pc12_err_set", bus.pc_err, 1);
        applyStimulus(3, LOCS_D3);
        waitDrain("pc12_next_drain");
        checkOutput("pc12_err_sticky", bus.pc_err, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("pc12_err_cleared", bus.pc_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/one_location_serializer.md
Name: one_location_serializer

Overview:
- Downstream consumer of the byte weight/location stage.
- Accepts one byte's worth of population count (PC) and ordered 1-locations (L0..L7).
- Emits the valid locations one per beat, lowest index first, on a valid/ready stream with last-beat marking and an end-of-byte done pulse.
- Feeds sparse/event-driven processing that only visits set bits.

Parameters:
- N, 8, number of location slots / bits per input byte (fixed design point; other values unsupported).
- LOC_W, 3, width of each location bus (log2 N).
- PC_W, 4, width of population count (log2 N + 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  PC/L0..L7 bundle is valid.
- in_ready  out  1  block can accept a bundle.
- PC  in  PC_W  population count, 0..8.
- L0..L7  in  LOC_W each  ordered 1-locations; only L0..L(PC-1) meaningful.
- loc_valid  out  1  loc holds a valid location.
- loc_ready  in  1  consumer accepts loc.
- loc  out  LOC_W  current bit location.
- loc_idx  out  LOC_W  ordinal of current beat within byte (0..PC-1).
- loc_last  out  1  current beat is the final location of the byte.
- done  out  1  one-cycle pulse when a byte completes (including PC==0).
- pc_err  out  1  sticky flag, set when an accepted PC > 8.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: in_ready=1, loc_valid=0, loc=0, loc_idx=0, loc_last=0, done=0, pc_err=0, FSM=IDLE, internal count=0.
- rst overrides everything in the same edge, including mid-byte; the remaining beats are dropped.
- FSM states: IDLE, EMIT.
- IDLE: in_ready=1.
  - On in_valid&in_ready, latch L0..L7 into an 8-entry holding register and latch min(PC,8) as cnt.
  - If latched cnt==0: stay IDLE and pulse done in the next cycle; no loc beat is produced.
  - Else go to EMIT with idx=0.
- EMIT: in_ready=0; loc_valid=1; loc=held[idx]; loc_idx=idx; loc_last=(idx==cnt-1).
  - Outputs come from registers and are stable while loc_valid&!loc_ready; a stalled beat never changes.
  - On loc_valid&loc_ready with !loc_last: idx increments.
  - On loc_valid&loc_ready with loc_last: go to IDLE, loc_valid=0 next cycle, done=1 for exactly one cycle.
- Latency: first loc_valid appears 1 cycle after input handshake. Throughput is 1 location per cycle with loc_ready held high.
  - Base build has a one-cycle IDLE bubble between bytes: a byte with PC=k occupies k+1 cycles.
- PC > 8: clamp to 8, set pc_err (cleared only by rst).
- loc_idx/loc never wrap: idx is bounded by cnt-1 ≤ 7.
- in_valid while in_ready=0: ignored; the upstream holds its bundle.
- done and the next input handshake may coincide (done refers to the previous byte).

Optional Feature:
- Macro: ONE_LOC_BACK_TO_BACK_EN.
- Defined: in_ready = IDLE | (loc_valid & loc_ready & loc_last).
  - A new bundle is accepted in the same cycle as the final beat.
  - A nonzero byte goes directly EMIT→EMIT with idx=0; a PC==0 byte goes to IDLE.
  - Removes the bubble: k cycles per byte.
  - done still pulses for the completed byte.
- Undefined: base behaviour with a one-cycle bubble between bytes.

Decomposition:
- Shared package one_loc_pkg:
  - N, LOC_W, PC_W constants.
  - FSM state enum {IDLE, EMIT}.
  - Helper constant MAX_PC=8.
- No sub-module required; the holding register, counter and FSM sit in one module.
- A top-level pairing with the weight locator stage is done at the integration level, not inside this block.

Test Plan:
- Byte 0xD3 → PC=5, L=0,1,4,6,7 with loc_ready=1 → loc beats 0,1,4,6,7 on consecutive cycles; loc_idx 0..4; loc_last only on loc=7; done one cycle later.
- Same bundle, loc_ready low on 2nd and 4th beats for 3 cycles each → loc/loc_idx held stable while stalled; sequence unchanged; total 5 accepted beats.
- PC=0 → no loc_valid; done pulses once; in_ready stays 1.
- Two bundles back to back, PC=8 (L=0..7) then PC=1 (L0=3):
  - Base build: 9+2 cycles, bubble between bytes.
  - ONE_LOC_BACK_TO_BACK_EN build: beat 3 directly follows beat 7.
- rst asserted mid-EMIT at idx=2 of PC=5 → next cycle all outputs at reset values; the following bundle starts at loc_idx=0.
- PC=12 accepted → pc_err=1 sticky; exactly 8 beats emitted; pc_err cleared only by rst.
